alu_ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of aludec and the ID/EX operand muxes.
- Consumes the 8-bit alucontrol code plus operands, computes the ALU result and overflow, and registers them with their control bits into a 2-entry skid-buffered output stage feeding EX/MEM.
- Valid/ready handshake on both sides. Full throughput of 1 op/cycle. Back-pressure from MEM never drops or duplicates an op.

---
 rtl/alu_ex_stage_pkg.sv | 39 +++
 rtl/alu_ex_stage_alu.sv | 62 ++++++
 rtl/alu_ex_stage.sv | 119 +++++++++++
 tb/tb_alu_ex_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ex_stage_pkg
//  Purpose  : ALU operation codes and datapath width shared by the EX stage
//  Revision : 1.0  initial release
// ============================================================================
package alu_ex_stage_pkg;

    localparam int ALU_DW = 32;

    // Logic
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP  = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP  = 8'b0101_1100;

    // Shifts
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP = 8'b0000_0111;

    // Arithmetic, compare, memory address, branch compare
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDI_OP = 8'b0101_0101;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [7:0] EXE_BEQ_OP  = 8'b0101_0001;
    localparam logic [7:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [7:0] EXE_SW_OP   = 8'b1110_1011;

endpackage
`default_nettype wire

// File: rtl/alu_ex_stage_alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ex_stage_alu
//  Purpose  : Combinational MIPS ALU: result and signed overflow per opcode
//  Revision : 1.0  initial release
// ============================================================================
module alu_ex_stage_alu
    import alu_ex_stage_pkg::*;
#(
    parameter int DW = ALU_DW
) (
    input  logic [7:0]    alucontrol,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [4:0]    sa,
    output logic [DW-1:0] result,
    output logic          overflow
);

    logic [DW-1:0] w_add;
    logic [DW-1:0] w_sub;

    assign w_add = a + b;
    assign w_sub = a - b;

    // Opcode decode; unknown codes yield zero result and no overflow
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alucontrol)
            EXE_AND_OP, EXE_ANDI_OP: result = a & b;
            EXE_OR_OP,  EXE_ORI_OP:  result = a | b;
            EXE_XOR_OP, EXE_XORI_OP: result = a ^ b;
            EXE_NOR_OP:              result = ~(a | b);
            EXE_LUI_OP:              result = {b[15:0], {(DW-16){1'b0}}};
            EXE_SLL_OP:              result = b << sa;
            EXE_SRL_OP:              result = b >> sa;
            EXE_SRA_OP:              result = $signed(b) >>> sa;
            EXE_SLLV_OP:             result = b << a[4:0];
            EXE_SRLV_OP:             result = b >> a[4:0];
            EXE_SRAV_OP:             result = $signed(b) >>> a[4:0];
            EXE_ADD_OP, EXE_ADDI_OP: begin
                result   = w_add;
                overflow = (a[DW-1] == b[DW-1]) && (w_add[DW-1] != a[DW-1]);
            end
            // Address arithmetic never traps
            EXE_LW_OP, EXE_SW_OP:    result = w_add;
            EXE_SUB_OP: begin
                result   = w_sub;
                overflow = (a[DW-1] != b[DW-1]) && (w_sub[DW-1] != a[DW-1]);
            end
            EXE_BEQ_OP:              result = w_sub;
            EXE_SLT_OP:              result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                result   = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ex_stage
//  Purpose  : MIPS execute stage - ALU plus 2-entry skid-buffered output
//             register with valid/ready handshake on both sides
//  Revision : 1.0  initial release
// ============================================================================
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    alucontrol,
    input  logic [DW-1:0] srca,
    input  logic [DW-1:0] srcb,
    input  logic [4:0]    sa,
    input  logic [RW-1:0] wreg,
    input  logic          regwrite_i,
    input  logic          memtoreg_i,
    input  logic          memwrite_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] aluresult,
    output logic          zero,
    output logic          overflow,
    output logic [DW-1:0] writedata,
    output logic [RW-1:0] wreg_o,
    output logic          regwrite_o,
    output logic          memtoreg_o,
    output logic          memwrite_o
);

    // Payload: result, zero, overflow, store data, dest reg, 3 control bits
    localparam int PW = 2 * DW + RW + 5;

    logic [DW-1:0] w_result;
    logic          w_overflow;
    logic [PW-1:0] w_new;
    logic          w_accept;
    logic          w_m_free;

    logic          r_m_valid;
    logic          r_s_valid;
    logic [PW-1:0] r_m;
    logic [PW-1:0] r_s;

    alu_ex_stage_alu #(.DW(DW)) u_alu (
        .alucontrol (alucontrol),
        .a          (srca),
        .b          (srcb),
        .sa         (sa),
        .result     (w_result),
        .overflow   (w_overflow)
    );

    // An overflowing op must not write the register file
    assign w_new = {w_result, (w_result == '0), w_overflow, srcb, wreg,
                    regwrite_i & ~w_overflow, memtoreg_i, memwrite_i};

    // in_ready comes straight from a flop: ready whenever the skid slot is empty
    assign in_ready = ~r_s_valid;
    assign w_accept = in_valid & in_ready;
    // Main register can take new contents if empty or emptying this cycle
    assign w_m_free = ~r_m_valid | out_ready;

    assign out_valid = r_m_valid;
    assign {aluresult, zero, overflow, writedata, wreg_o,
            regwrite_o, memtoreg_o, memwrite_o} = r_m;

    // Occupancy of main and skid entries; flush dominates everything else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else begin
                r_m_valid <= w_accept;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
        end
    end

    // Main payload: skid entry has priority (it is older than any new op)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m <= '0;
        end else if (!flush && w_m_free) begin
            if (r_s_valid) begin
                r_m <= r_s;
            end else if (w_accept) begin
                r_m <= w_new;
            end
        end
    end

    // Skid payload captures an op accepted while the main entry is stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s <= '0;
        end else if (!flush && !w_m_free && w_accept) begin
            r_s <= w_new;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ex_stage
//  Purpose  : Self-checking bench for alu_ex_stage (scoreboard + ref model)
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ex_stage;
    import alu_ex_stage_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ov;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        rw;
        logic        mtr;
        logic        mw;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [4:0]  sa;
    logic [4:0]  wreg;
    logic        regwrite_i;
    logic        memtoreg_i;
    logic        memwrite_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluresult;
    logic        zero;
    logic        overflow;
    logic [31:0] writedata;
    logic [4:0]  wreg_o;
    logic        regwrite_o;
    logic        memtoreg_o;
    logic        memwrite_o;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_ex_stage #(.DW(32), .RW(5)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .sa         (sa),
        .wreg       (wreg),
        .regwrite_i (regwrite_i),
        .memtoreg_i (memtoreg_i),
        .memwrite_i (memwrite_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .aluresult  (aluresult),
        .zero       (zero),
        .overflow   (overflow),
        .writedata  (writedata),
        .wreg_o     (wreg_o),
        .regwrite_o (regwrite_o),
        .memtoreg_o (memtoreg_o),
        .memwrite_o (memwrite_o)
    );

    always #5 clk = ~clk;

    // Reference model: MIPS semantics with wide signed arithmetic
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, b,
                                   input logic [4:0] s, w, input logic rw, mtr, mw);
        exp_t        e;
        longint      as_l, bs_l, wide;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        ov;
        as_l = longint'($signed(a));
        bs_l = longint'($signed(b));
        r    = 32'h0;
        ov   = 1'b0;
        sh   = s;
        if (op == EXE_SLLV_OP || op == EXE_SRLV_OP || op == EXE_SRAV_OP) sh = a[4:0];
        case (op)
            EXE_AND_OP, EXE_ANDI_OP: r = a & b;
            EXE_OR_OP,  EXE_ORI_OP:  r = a | b;
            EXE_XOR_OP, EXE_XORI_OP: r = a ^ b;
            EXE_NOR_OP:              r = ~(a | b);
            EXE_LUI_OP:              r = b * 32'd65536;
            EXE_SLL_OP, EXE_SLLV_OP: r = b << sh;
            EXE_SRL_OP, EXE_SRLV_OP: r = b >> sh;
            EXE_SRA_OP, EXE_SRAV_OP: r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            EXE_ADD_OP, EXE_ADDI_OP, EXE_LW_OP, EXE_SW_OP: begin
                wide = as_l + bs_l;
                r    = wide[31:0];
                if (op == EXE_ADD_OP || op == EXE_ADDI_OP)
                    ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            EXE_SUB_OP, EXE_BEQ_OP: begin
                wide = as_l - bs_l;
                r    = wide[31:0];
                if (op == EXE_SUB_OP)
                    ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            EXE_SLT_OP: r = (as_l < bs_l) ? 32'd1 : 32'd0;
            default:    r = 32'h0;
        endcase
        e.res   = r;
        e.zero  = (r == 32'h0);
        e.ov    = ov;
        e.wdata = b;
        e.wreg  = w;
        e.rw    = rw & ~ov;
        e.mtr   = mtr;
        e.mw    = mw;
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1'b1));
        chk({tag, "_data"}, 128'({aluresult, zero, overflow, writedata, wreg_o,
                                  regwrite_o, memtoreg_o, memwrite_o}), 128'h0);
    endtask

    // One clock of stimulus; the expected response is queued if the op is accepted
    task automatic cycle(input logic v, input logic [7:0] op, input logic [31:0] a, b,
                         input logic [4:0] s, w, input logic rw, mtr, mw, ordy, fl);
        @(posedge clk);
        #1;
        in_valid   = v;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        sa         = s;
        wreg       = w;
        regwrite_i = rw;
        memtoreg_i = mtr;
        memwrite_i = mw;
        out_ready  = ordy;
        flush      = fl;
        @(negedge clk);
        if (resetn) begin
            if (fl) sb.delete();
            else if (v && in_ready) sb.push_back(model(op, a, b, s, w, rw, mtr, mw));
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 8'h00, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    // Monitor: every output transfer is matched against the oldest expected op
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h expected=none", aluresult);
                end else begin
                    e = sb.pop_front();
                    chk("sb_output", 128'({aluresult, zero, overflow, writedata, wreg_o,
                                          regwrite_o, memtoreg_o, memwrite_o}), 128'(e));
                end
            end
        end
    end

    // Driver
    initial begin
        logic [7:0]  ops [21];
        logic [31:0] corner [6];
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        fl, ordy;
        int          guard;

        ops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_ANDI_OP, EXE_ORI_OP,
                EXE_XORI_OP, EXE_LUI_OP, EXE_SLL_OP, EXE_SLLV_OP, EXE_SRL_OP, EXE_SRLV_OP,
                EXE_SRA_OP, EXE_SRAV_OP, EXE_SLT_OP, EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP,
                EXE_BEQ_OP, EXE_LW_OP, EXE_SW_OP};
        corner = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h8000_00F0};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; alucontrol = 8'h0;
        srca = 32'h0; srcb = 32'h0; sa = 5'd0; wreg = 5'd0;
        regwrite_i = 1'b0; memtoreg_i = 1'b0; memwrite_i = 1'b0; out_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back directed ops, each checked the cycle after issue
        cycle(1, EXE_ADD_OP,  32'h7FFF_FFFF, 32'h1,         5'd0, 5'd3, 1, 0, 0, 1, 0);
        cycle(1, EXE_SRAV_OP, 32'h4,         32'h8000_00F0, 5'd0, 5'd4, 1, 0, 0, 1, 0);
        chk("add_ovf_result",   128'(aluresult),  128'h8000_0000);
        chk("add_ovf_flag",     128'(overflow),   128'h1);
        chk("add_ovf_regwrite", 128'(regwrite_o), 128'h0);
        chk("add_ovf_valid",    128'(out_valid),  128'h1);
        cycle(1, EXE_SLT_OP,  32'hFFFF_FFFF, 32'h1,         5'd0, 5'd5, 1, 0, 0, 1, 0);
        chk("srav_result", 128'(aluresult), 128'hF800_000F);
        cycle(1, EXE_BEQ_OP,  32'h1234,      32'h1234,      5'd0, 5'd0, 0, 0, 0, 1, 0);
        chk("slt_result", 128'(aluresult), 128'h1);
        chk("slt_zero",   128'(zero),      128'h0);
        idle(1);
        chk("beq_result", 128'(aluresult), 128'h0);
        chk("beq_zero",   128'(zero),      128'h1);
        chk("beq_ovf",    128'(overflow),  128'h0);
        idle(1);

        // Back-pressure: A held, B parked in skid, then both drain in order
        cycle(1, EXE_OR_OP,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 5'd7, 1, 0, 0, 0, 0);
        cycle(1, EXE_LUI_OP, 32'h0,         32'h0000_ABCD, 5'd0, 5'd8, 1, 1, 0, 0, 0);
        chk("bp_a_out",      128'(aluresult), 128'hF0F0_0F0F);
        chk("bp_ready_high", 128'(in_ready),  128'h1);
        idle(0);
        chk("bp_ready_low",  128'(in_ready),  128'h0);
        chk("bp_a_stable",   128'({out_valid, aluresult, wreg_o}), 128'({1'b1, 32'hF0F0_0F0F, 5'd7}));
        idle(1);
        chk("bp_a_emerge",   128'(aluresult), 128'hF0F0_0F0F);
        idle(1);
        chk("bp_b_emerge",   128'({out_valid, aluresult, wreg_o}), 128'({1'b1, 32'hABCD_0000, 5'd8}));
        chk("bp_ready_back", 128'(in_ready),  128'h1);
        idle(1);
        chk("bp_drained",    128'(out_valid), 128'h0);

        // Flush with both entries full and a new op offered
        cycle(1, EXE_AND_OP, 32'hFF, 32'h0F, 5'd0, 5'd1, 1, 0, 0, 0, 0);
        cycle(1, EXE_XOR_OP, 32'hFF, 32'h0F, 5'd0, 5'd2, 1, 0, 0, 0, 0);
        cycle(1, EXE_NOR_OP, 32'h0,  32'h0,  5'd0, 5'd3, 1, 0, 0, 0, 1);
        idle(1);
        chk("flush_full_valid", 128'(out_valid), 128'h0);
        chk("flush_full_ready", 128'(in_ready),  128'h1);
        // Flush dropping an op that would otherwise have been accepted
        cycle(1, EXE_ORI_OP, 32'h10, 32'h01, 5'd0, 5'd9,  1, 0, 0, 0, 0);
        cycle(1, EXE_SUB_OP, 32'h5,  32'h3,  5'd0, 5'd10, 1, 0, 1, 0, 1);
        idle(1);
        chk("flush_drop_valid", 128'(out_valid), 128'h0);
        idle(1);
        chk("flush_drop_never", 128'(out_valid), 128'h0);

        // Random stream with a single asynchronous reset pulse in the middle
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                @(posedge clk);
                #1;
                resetn   = 1'b0;
                in_valid = 1'b0;
                flush    = 1'b0;
                #1;
                chk_reset_outputs("midreset");
                sb.delete();
                @(negedge clk);
                resetn = 1'b1;
            end
            op = ops[$urandom_range(0, 20)];
            if ($urandom_range(0, 15) == 0) op = 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            fl   = ($urandom_range(0, 63) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 2) != 0);
            cycle($urandom_range(0, 3) != 0, op, a, b, 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ordy, fl);
        end

        // Drain with a bounded wait
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("drain_pending", 128'(sb.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
